bin_to_gray_conv: RTL and testbench
===================================

Name:
bin_to_gray_conv

Overview:
- Registered, parameterizable code converter between binary and reflected Gray code.
- Default direction is binary-to-Gray. A mode input selects the inverse, Gray-to-binary.
- Used in counter/pointer paths, e.g. clock-domain-crossing FIFO pointers, where single-bit-change encoding is required.
- One cycle of latency with a simple valid qualifier.

Parameters:
- WIDTH, 3, bit width of input and output code words (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and mode are valid this cycle.
- mode  input  1  0 = binary-to-Gray; 1 = Gray-to-binary.
- in_data  input  WIDTH  code word to convert.
- out_valid  output  1  out_data holds a new result this cycle.
- out_data  output  WIDTH  converted code word.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n = 0: out_valid = 0 and out_data = 0, immediately, without waiting for a clock edge.
  - Deassertion is sampled on the next rising clk edge.
- Binary-to-Gray (mode = 0):
  - g[WIDTH-1] = b[WIDTH-1].
  - g[i] = b[i+1] XOR b[i] for i < WIDTH-1.
  - Equivalently g = b XOR (b >> 1).
- Gray-to-binary (mode = 1):
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i], a prefix XOR from the MSB down.
  - Purely combinational before the output register; no iteration across cycles.
- Latency is exactly 1 cycle.
  - in_valid = 1 at edge N gives out_valid = 1 and out_data = f(in_data, mode) after edge N.
  - in_valid = 0 at an edge gives out_valid = 0 the following cycle; out_data holds its last value.
- Full throughput: back-to-back valid inputs produce back-to-back outputs. There is no backpressure.
- mode may change on any cycle. Each output uses the mode sampled with its own input.
- Wrap-around: for binary input all-ones, the Gray output is 1 followed by WIDTH-1 zeros. The next binary input, 0, gives Gray 0, a one-bit change.
- WIDTH = 1: the output equals the input in both modes.
- Reset mid-stream: any in-flight result is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- When defined, add an output step_err (1 bit), registered, reset to 0.
  - Tracks the previous valid output produced in mode 0.
  - On each mode-0 valid output, step_err = 1 for that output cycle if the new Gray word differs from the previous one in more than one bit position. Otherwise step_err = 0.
  - The first mode-0 output after reset never flags.
  - Mode-1 outputs never flag and do not update the tracked value.
  - step_err = 0 whenever out_valid = 0.
- When not defined: the step_err port and its tracking register do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package gray_pkg holds:
  - constant MODE_B2G = 1'b0 and constant MODE_G2B = 1'b1;
  - pure functions bin2gray(WIDTH) and gray2bin(WIDTH), reusable by FIFO pointer logic.
- One natural sub-module: gray_step_check, holding the previous-value register plus popcount-greater-than-1 logic. It is instantiated only under GRAY_STEP_CHECK_EN.
- The conversion logic stays in the top module, using the package functions.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 and in_data = 3'b101 -> out_valid = 0, out_data = 000 throughout. Release rst_n -> the first output appears one cycle after the first sampled in_valid.
- Binary-to-Gray sweep, mode = 0, back-to-back inputs 000..111 -> outputs one cycle later 000, 001, 011, 010, 110, 111, 101, 100, with out_valid high for 8 consecutive cycles.
- Gray-to-binary sweep, mode = 1, inputs 000, 001, 011, 010, 110, 111, 101, 100 -> outputs 000..111. Round-trip of all 8 codes matches.
- Gaps and hold: send 3'b110 (mode 0), then in_valid = 0 for 3 cycles -> out_data = 101 is held, out_valid = 1 for one cycle, then 0.
- Mode switch per cycle: send mode 0 with 011, then mode 1 with 011 -> outputs 010, then 010 on consecutive cycles.
- With GRAY_STEP_CHECK_EN, mode 0:
  - Inputs 000, 001, 010 -> step_err 0, 0, 0.
  - Then input 101 (Gray 111, versus previous 011) -> step_err 0.
  - Then input 000 (Gray 000, versus 111) -> step_err = 1.
  - Then assert reset -> step_err = 0 immediately.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gray_pkg
// Description : Shared constants and pure conversion functions for reflected
//               Gray code. Used by bin_to_gray_conv and reusable by FIFO
//               pointer logic. The functions work on a zero-extended word of
//               GRAY_MAX_W bits; callers cast the result back to their width.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  // Direction select values for the converter's mode input.
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Widest code word the shared functions handle.
  localparam int GRAY_MAX_W = 64;

  // Binary to Gray: every bit XORed with its upper neighbour.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(
    input logic [GRAY_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB downwards. Zero upper bits
  // leave the result unchanged, so narrow callers just zero-extend.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] g
  );
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_step_check.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_check
// Description : Flags a binary-to-Gray result that differs from the previous
//               binary-to-Gray result in more than one bit. Result is
//               registered alongside the converter output. Only built when
//               GRAY_STEP_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_step_check
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,   // a result is being registered this edge
  input  logic             mode_i,    // direction of that result
  input  logic [WIDTH-1:0] word_i,    // the result being registered
  output logic             step_err_o
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             step_err_q, step_err_d;

  logic [WIDTH-1:0] w_diff;
  logic             w_multi_bit;
  logic             w_track;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_diff      = word_i ^ prev_q;
  assign w_multi_bit = |(w_diff & (w_diff - WIDTH'(1)));
  assign w_track     = valid_i && (mode_i == MODE_B2G);

  // Next-state: only binary-to-Gray results are compared and tracked.
  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    step_err_d  = 1'b0;
    if (w_track) begin
      step_err_d  = have_prev_q && w_multi_bit;
      prev_d      = word_i;
      have_prev_d = 1'b1;
    end
  end

  // Tracking registers; reset forgets history so the next result never flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      step_err_q  <= step_err_d;
    end
  end

  assign step_err_o = step_err_q;

endmodule : gray_step_check
`default_nettype wire

// File: rtl/bin_to_gray_conv.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_gray_conv
// Description : Registered binary <-> reflected Gray converter, one cycle of
//               latency, full throughput. mode = 0 converts binary to Gray,
//               mode = 1 converts Gray to binary; mode travels with its data.
//               Optional macro GRAY_STEP_CHECK_EN adds the step_err output
//               (multi-bit change between successive binary-to-Gray results).
//               WIDTH must lie in 1..GRAY_MAX_W.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [GRAY_MAX_W-1:0] w_in_ext;
  logic [WIDTH-1:0]      w_conv;

  assign w_in_ext = GRAY_MAX_W'(in_data);

  // Conversion in the selected direction, fully combinational.
  always_comb begin
    w_conv = WIDTH'(bin2gray(w_in_ext));
    if (mode == MODE_G2B) begin
      w_conv = WIDTH'(gray2bin(w_in_ext));
    end
  end

  // Next-state: capture a new result on valid input, otherwise hold the data.
  always_comb begin
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    if (in_valid) begin
      out_data_d = w_conv;
    end
  end

  // Output register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef GRAY_STEP_CHECK_EN
  gray_step_check #(
    .WIDTH (WIDTH)
  ) u_step_check (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (in_valid),
    .mode_i     (mode),
    .word_i     (w_conv),
    .step_err_o (step_err)
  );
`endif

endmodule : bin_to_gray_conv
`default_nettype wire

// File: tb/tb_bin_to_gray_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_gray_conv
// Description : Scoreboard bench for bin_to_gray_conv. Stimulus pushes
//               expected results into a queue; a monitor pops and compares
//               whenever the DUT presents out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_gray_conv;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef GRAY_STEP_CHECK_EN
  logic         step_err;
`endif

  bin_to_gray_conv #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef GRAY_STEP_CHECK_EN
    ,
    .step_err  (step_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cycle = 0;
  logic [W-1:0] last_exp = '0;
  logic [W-1:0] mdl_prev = '0;
  bit           mdl_have = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: Gray = b XOR (b >> 1); inverse found by searching all codes.
  function automatic logic [W-1:0] ref_conv(input bit m, input logic [W-1:0] d);
    logic [W-1:0] b;
    if (!m) return d ^ (d >> 1);
    for (int i = 0; i < (1 << W); i++) begin
      b = W'(i);
      if ((b ^ (b >> 1)) == d) return b;
    end
    return 'x;
  endfunction

  always @(posedge clk) cycle++;

  // Monitor: compares DUT output shortly after every rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_data", 32'(out_data), 32'd0);
      last_exp = '0;
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got out_valid=1 data=%0h, expected no output (t=%0t)",
                 out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("data", 32'(out_data), 32'(e.data));
        check("latency_cycle", 32'(cycle), 32'(e.cyc));
`ifdef GRAY_STEP_CHECK_EN
        check("step_err", 32'(step_err), 32'(e.err));
`endif
        last_exp = e.data;
      end
    end else begin
      check("idle_valid", 32'(out_valid), 32'd0);
      check("hold_data", 32'(out_data), 32'(last_exp));
`ifdef GRAY_STEP_CHECK_EN
      check("idle_step_err", 32'(step_err), 32'd0);
`endif
    end
  end

  // Drive one cycle of input; expected result pushed when it will be sampled.
  task automatic drive(input bit v, input bit m, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    mode     = m;
    in_data  = d;
    if (v && rst_n) begin
      e.data = ref_conv(m, d);
      e.err  = 1'b0;
      if (!m) begin
        if (mdl_have && $countones(e.data ^ mdl_prev) > 1) e.err = 1'b1;
        mdl_prev = e.data;
        mdl_have = 1;
      end
      e.cyc = cycle + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
`ifdef GRAY_STEP_CHECK_EN
    check({tag, "_step_err"}, 32'(step_err), 32'd0);
`endif
    exp_q.delete();
    mdl_have = 0;
  endtask

  initial begin
    // Reset held with valid input present: outputs stay cleared.
    in_valid = 1'b1;
    mode     = 1'b0;
    in_data  = 3'b101;
    #1;
    check("reset_immediate_valid", 32'(out_valid), 32'd0);
    check("reset_immediate_data", 32'(out_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Binary-to-Gray sweep, back-to-back.
    for (int i = 0; i < 8; i++) drive(1, 0, W'(i));
    // Gray-to-binary sweep over the Gray sequence.
    for (int i = 0; i < 8; i++) drive(1, 1, W'(i) ^ (W'(i) >> 1));

    // Single result followed by a gap: data held, valid for one cycle.
    drive(1, 0, 3'b110);
    repeat (3) drive(0, 0, W'($urandom));

    // Mode switching on consecutive cycles.
    drive(1, 0, 3'b011);
    drive(1, 1, 3'b011);

    // Reset mid-stream: in-flight input discarded, valid drops at once.
    drive(1, 0, 3'b111);
    #2;
    async_reset_check("midstream_reset");
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Step sequence: last input gives a three-bit Gray change.
    drive(1, 0, 3'b000);
    drive(1, 0, 3'b001);
    drive(1, 0, 3'b010);
    drive(1, 0, 3'b101);
    drive(1, 0, 3'b000);
    drive(0, 0, 3'b000);
    @(posedge clk);
    #2;
    async_reset_check("step_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with gaps and mode changes.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), W'($urandom));
    end

    // Wrap-around at the end of a binary count.
    drive(1, 0, 3'b111);
    drive(1, 0, 3'b000);
    drive(0, 0, 3'b000);
    drive(0, 0, 3'b000);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bin_to_gray_conv
`default_nettype wire
